seq_matmul_int_param: RTL and testbench

- Next-generation sequential matrix multiplier. Computes Z = A×B for rectangular A (M×K) and B (K×N) of signed fixed-point integers.
- Uses a single in-block pipelined MAC, so no external handshaked float units are needed.
- Fetches operands through row/column address ports from external synchronous memories (read latency 1).
- Emits each Z element with coordinates over a z_stb/z_ack handshake. Sits between operand RAMs and the result sink/RAM in the accelerator datapath.

---
 rtl/seq_matmul_int_param.sv | 158 +++++++++++++++
 tb/tb_seq_matmul_int_param.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_matmul_int_param.sv
// Sequential signed integer matrix multiplier Z = A x B with one in-block MAC.
// Define SEQ_MATMUL_SAT_EN to saturate z_out instead of wrapping it.
module seq_matmul_int_param #(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              z_ack,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] a_i,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] a_j,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] b_i,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] b_j,
    output logic [OUT_W-1:0]  z_out,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] z_i,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] z_j,
    output logic              z_stb,
    output logic              busy,
    output logic              done
);
    localparam int MW    = (M > 1) ? $clog2(M) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int NW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * DATA_W + KW;

    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_OUT,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic [MW-1:0]              r_i;
    logic [KW-1:0]              r_k;
    logic [NW-1:0]              r_j;
    logic                       r_pipe_v;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_acc_nxt;
    logic signed [OUT_W-1:0]    w_red;

    // Operand addresses follow the loop counters directly.
    assign a_i = r_i;
    assign a_j = r_k;
    assign b_i = r_k;
    assign b_j = r_j;

    // MAC: product of the operands fetched one cycle earlier.
    assign w_prod    = $signed(a_in) * $signed(b_in);
    assign w_acc_nxt = r_pipe_v ? r_acc + ACC_W'(w_prod) : r_acc;

    // Reduce the accumulator to the output width.
    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign w_red = OUT_W'(w_acc_nxt);
        end else begin : g_red
`ifdef SEQ_MATMUL_SAT_EN
            logic [ACC_W-OUT_W:0] w_top;
            logic                 w_fits;
            assign w_top  = w_acc_nxt[ACC_W-1:OUT_W-1];
            assign w_fits = (&w_top) | ~(|w_top);
            assign w_red  = w_fits ? w_acc_nxt[OUT_W-1:0] :
                            w_acc_nxt[ACC_W-1] ?
                            {1'b1, {(OUT_W-1){1'b0}}} :
                            {1'b0, {(OUT_W-1){1'b1}}};
`else
            assign w_red = w_acc_nxt[OUT_W-1:0];
`endif
        end
    endgenerate

    // Control FSM, loop counters, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_pipe_v <= 1'b0;
            r_acc    <= '0;
            z_out    <= '0;
            z_i      <= '0;
            z_j      <= '0;
            z_stb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_pipe_v <= 1'b1;
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_state <= S_FLUSH;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_pipe_v <= 1'b0;
                    z_out    <= w_red;
                    z_i      <= r_i;
                    z_j      <= r_j;
                    z_stb    <= 1'b1;
                    r_state  <= S_OUT;
                end
                S_OUT: begin
                    if (z_ack && z_stb) begin
                        z_stb <= 1'b0;
                        r_acc <= '0;
                        if (r_j == N_LAST) begin
                            r_j <= '0;
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                        if (r_i == M_LAST && r_j == N_LAST) begin
                            r_i     <= '0;
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_matmul_int_param.sv
// Directed bench for seq_matmul_int_param: four instances of differing shape.
// Expected values are hand-computed and held in local tables.
module tb_seq_matmul_int_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---- default 4x4x4 instance ----
    logic d_start = 1'b0, d_ack = 1'b0;
    logic signed [15:0] d_a_in, d_b_in;
    logic [1:0] d_a_i, d_a_j, d_b_i, d_b_j, d_z_i, d_z_j;
    logic [31:0] d_z_out;
    logic d_z_stb, d_busy, d_done;
    logic signed [15:0] DA [4][4];
    logic signed [15:0] DB [4][4];

    seq_matmul_int_param u_d (
        .clk(clk), .rst_n(rst_n), .start(d_start),
        .a_in(d_a_in), .b_in(d_b_in), .z_ack(d_ack),
        .a_i(d_a_i), .a_j(d_a_j), .b_i(d_b_i), .b_j(d_b_j),
        .z_out(d_z_out), .z_i(d_z_i), .z_j(d_z_j),
        .z_stb(d_z_stb), .busy(d_busy), .done(d_done)
    );
    always @(posedge clk) begin
        d_a_in <= DA[d_a_i][d_a_j];
        d_b_in <= DB[d_b_i][d_b_j];
    end

    // ---- 2x3x2 instance, z_ack tied high ----
    logic a_start = 1'b0;
    logic a_ack = 1'b1;
    logic signed [15:0] a_a_in, a_b_in;
    logic a_a_i, a_b_j, a_z_i, a_z_j;
    logic [1:0] a_a_j, a_b_i;
    logic [31:0] a_z_out;
    logic a_z_stb, a_busy, a_done;
    logic signed [15:0] AA [2][3];
    logic signed [15:0] AB [3][2];

    seq_matmul_int_param #(.M(2), .K(3), .N(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .a_in(a_a_in), .b_in(a_b_in), .z_ack(a_ack),
        .a_i(a_a_i), .a_j(a_a_j), .b_i(a_b_i), .b_j(a_b_j),
        .z_out(a_z_out), .z_i(a_z_i), .z_j(a_z_j),
        .z_stb(a_z_stb), .busy(a_busy), .done(a_done)
    );
    always @(posedge clk) begin
        a_a_in <= AA[a_a_i][a_a_j];
        a_b_in <= AB[a_b_i][a_b_j];
    end

    // ---- 1x4x1 instance with 16-bit output ----
    logic s_start = 1'b0;
    logic s_ack = 1'b1;
    logic signed [15:0] s_a_in, s_b_in, s_aval, s_bval;
    logic s_a_i, s_b_j, s_z_i, s_z_j;
    logic [1:0] s_a_j, s_b_i;
    logic [15:0] s_z_out;
    logic s_z_stb, s_busy, s_done;

    seq_matmul_int_param #(.M(1), .K(4), .N(1), .OUT_W(16)) u_s (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .a_in(s_a_in), .b_in(s_b_in), .z_ack(s_ack),
        .a_i(s_a_i), .a_j(s_a_j), .b_i(s_b_i), .b_j(s_b_j),
        .z_out(s_z_out), .z_i(s_z_i), .z_j(s_z_j),
        .z_stb(s_z_stb), .busy(s_busy), .done(s_done)
    );
    always @(posedge clk) begin
        s_a_in <= s_aval;
        s_b_in <= s_bval;
    end

    // ---- 1x1x1 instance ----
    logic o_start = 1'b0, o_ack = 1'b0;
    logic signed [15:0] o_a_in, o_b_in;
    logic o_a_i, o_a_j, o_b_i, o_b_j, o_z_i, o_z_j;
    logic [31:0] o_z_out;
    logic o_z_stb, o_busy, o_done;

    seq_matmul_int_param #(.M(1), .K(1), .N(1)) u_o (
        .clk(clk), .rst_n(rst_n), .start(o_start),
        .a_in(o_a_in), .b_in(o_b_in), .z_ack(o_ack),
        .a_i(o_a_i), .a_j(o_a_j), .b_i(o_b_i), .b_j(o_b_j),
        .z_out(o_z_out), .z_i(o_z_i), .z_j(o_z_j),
        .z_stb(o_z_stb), .busy(o_busy), .done(o_done)
    );
    always @(posedge clk) begin
        o_a_in <= (o_a_i == 1'b0 && o_a_j == 1'b0) ? -16'sd3 : 16'sd0;
        o_b_in <= (o_b_i == 1'b0 && o_b_j == 1'b0) ? 16'sd5 : 16'sd0;
    end

    typedef struct {
        int zi;
        int zj;
        int zv;
    } zvec_t;

    typedef struct {
        int a;
        int b;
        int wrap;
        int sat;
    } svec_t;

    // Full 4x4 multiply on u_d with random sink stalls of up to maxd cycles.
    task automatic run_d(int maxd);
        int t;
        int dly;
        logic [35:0] snap;
        d_ack = 1'b0;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        for (int e = 0; e < 16; e++) begin
            t = 0;
            while (!d_z_stb && t < 50) begin
                step();
                t++;
            end
            chk("d_stb_wait", t < 50, 1);
            chk("d_zi", d_z_i, e / 4);
            chk("d_zj", d_z_j, e % 4);
            chk("d_zout", $signed(d_z_out), DB[e/4][e%4]);
            snap = {d_z_stb, d_z_i, d_z_j, d_z_out[30:0]};
            dly = $urandom_range(0, maxd);
            for (int s = 0; s < dly; s++) begin
                step();
                chk("d_hold", {d_z_stb, d_z_i, d_z_j, d_z_out[30:0]}, snap);
            end
            d_ack = 1'b1;
            step();
            d_ack = 1'b0;
        end
        t = 0;
        while (!d_done && t < 10) begin
            step();
            t++;
        end
        chk("d_done_seen", d_done, 1);
        step();
        chk("d_busy_after", d_busy, 0);
        chk("d_done_once", d_done, 0);
    endtask

    initial begin
        zvec_t ta [4];
        svec_t sv [4];
        int cyc;
        int idx;
        int t;

        ta[0] = '{0, 0, 58};
        ta[1] = '{0, 1, 64};
        ta[2] = '{1, 0, 139};
        ta[3] = '{1, 1, 154};
        sv[0] = '{32767, 32767, 4, 32767};
        sv[1] = '{-32768, 32767, 0, -32768};
        sv[2] = '{-3, 7, -84, -84};
        sv[3] = '{-32768, -32768, 0, 32767};

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                DA[r][c] = (r == c) ? 16'sd1 : 16'sd0;
                DB[r][c] = 16'(r * 4 + c - 8);
            end
        AA = '{'{16'sd1, 16'sd2, 16'sd3}, '{16'sd4, 16'sd5, 16'sd6}};
        AB = '{'{16'sd7, 16'sd8}, '{16'sd9, 16'sd10}, '{16'sd11, 16'sd12}};
        s_aval = '0;
        s_bval = '0;

        // reset state
        step(2);
        chk("rst_stb", d_z_stb, 0);
        chk("rst_busy", d_busy, 0);
        chk("rst_done", d_done, 0);
        chk("rst_zout", d_z_out, 0);
        chk("rst_addr", {d_a_i, d_a_j, d_b_i, d_b_j}, 0);
        rst_n = 1'b1;
        step();

        // 2x3x2 table with z_ack high
        cyc = 0;
        idx = 0;
        a_start = 1'b1;
        step();
        cyc = 1;
        a_start = 1'b0;
        while (!a_done && cyc < 60) begin
            if (a_z_stb) begin
                if (idx == 0) chk("a_first_stb", cyc, 5);
                if (idx < 4) begin
                    chk("a_zi", a_z_i, ta[idx].zi);
                    chk("a_zj", a_z_j, ta[idx].zj);
                    chk("a_zout", $signed(a_z_out), ta[idx].zv);
                end
                idx++;
            end
            step();
            cyc++;
        end
        chk("a_done_cycle", cyc, 21);
        chk("a_elem_count", idx, 4);
        chk("a_busy_in_done", a_busy, 1);
        step();
        chk("a_done_pulse", a_done, 0);
        chk("a_busy_idle", a_busy, 0);

        // identity x B with random stalls
        run_d(3);

        // output reduction table
        for (int v = 0; v < 4; v++) begin
            s_aval = 16'(sv[v].a);
            s_bval = 16'(sv[v].b);
            s_start = 1'b1;
            step();
            s_start = 1'b0;
            t = 0;
            while (!s_z_stb && t < 20) begin
                step();
                t++;
            end
            chk("s_stb_wait", t < 20, 1);
`ifdef SEQ_MATMUL_SAT_EN
            chk("s_zout_sat", $signed(s_z_out), sv[v].sat);
`else
            chk("s_zout_wrap", $signed(s_z_out), sv[v].wrap);
`endif
            t = 0;
            while (!s_done && t < 10) begin
                step();
                t++;
            end
            chk("s_done", s_done, 1);
            step();
        end

        // 1x1x1 with start pulses while busy
        o_start = 1'b1;
        step();
        o_start = 1'b0;
        step();
        o_start = 1'b1;
        chk("o_stb_early", o_z_stb, 0);
        step();
        o_start = 1'b0;
        chk("o_stb_at3", o_z_stb, 1);
        chk("o_zout", $signed(o_z_out), -15);
        o_start = 1'b1;
        step();
        o_start = 1'b0;
        chk("o_hold_stb", o_z_stb, 1);
        chk("o_hold_zout", $signed(o_z_out), -15);
        o_ack = 1'b1;
        step();
        o_ack = 1'b0;
        chk("o_done", o_done, 1);
        chk("o_stb_clr", o_z_stb, 0);
        step();
        chk("o_done_once", o_done, 0);
        chk("o_busy_idle", o_busy, 0);
        step();
        chk("o_no_restart", o_busy, 0);

        // reset during RUN of element (1,2)
        d_ack = 1'b1;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        t = 0;
        while (!(d_busy && d_a_i == 2'd1 && d_b_j == 2'd2 && !d_z_stb) && t < 200) begin
            step();
            t++;
        end
        chk("rst_reach_12", t < 200, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stb", d_z_stb, 0);
        chk("mid_rst_busy", d_busy, 0);
        chk("mid_rst_outs", {d_done, d_z_out, d_z_i, d_z_j}, 0);
        chk("mid_rst_addr", {d_a_i, d_a_j, d_b_i, d_b_j}, 0);
        d_ack = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();
        run_d(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
